// File: rtl/a3_debounce_cnt.sv
// Debounced 3-input AND condition with rise pulse, saturating event counter and
// 4-phase snapshot readout. Define A3_DEBOUNCE_SYNC_EN for 2-flop input synchronisers.
module a3_debounce_cnt #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 8
) (
   input  logic             ck,
   input  logic             nrst,
   input  logic             i0,
   input  logic             i1,
   input  logic             i2,
   output logic             q,
   output logic             qrise,
   output logic [CNT_W-1:0] cnt,
   output logic             cnt_sat,
   input  logic             snap_req,
   output logic             snap_vld,
   output logic [CNT_W-1:0] snap_cnt
);

   localparam int STAB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic {IDLE, HELD} snap_st_e;

   logic [2:0]        sync;
   logic              s;
   logic [STAB_W-1:0] stab;
   logic              flip;
   logic              rise;
   logic [CNT_W-1:0]  cnt_inc;
   logic [CNT_W-1:0]  cnt_d;
   logic              capture;
   snap_st_e          state, state_nxt;

`ifdef A3_DEBOUNCE_SYNC_EN
   logic [2:0] meta;

   always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= {i2, i1, i0};
         sync <= meta;
      end
   end
`else
   always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) sync <= '0;
      else       sync <= {i2, i1, i0};
   end
`endif

   assign s = &sync;

   // q follows s only after DB_CYCLES consecutive disagreeing edges
   assign flip = (s != q) && (stab == STAB_LAST);
   assign rise = flip & s;

   always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) begin
         stab  <= '0;
         q     <= 1'b0;
         qrise <= 1'b0;
      end else begin
         qrise <= rise;
         if (s == q) begin
            stab <= '0;
         end else if (flip) begin
            stab <= '0;
            q    <= s;
         end else begin
            stab <= stab + 1'b1;
         end
      end
   end

   assign cnt_inc = (rise && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE: if (snap_req) begin
            capture   = 1'b1;
            state_nxt = HELD;
         end
         HELD: if (!snap_req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // a rise on the capture edge lands in snap_cnt, the live counter restarts at 0
   assign cnt_d = capture ? '0 : cnt_inc;

   always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         cnt      <= '0;
         cnt_sat  <= 1'b0;
         snap_cnt <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_d;
         cnt_sat <= (cnt_d == CNT_MAX);
         if (capture) snap_cnt <= cnt_inc;
      end
   end

   assign snap_vld = (state == HELD);

endmodule

// File: tb/tb_a3_debounce_cnt.sv
// Randomised bench for a3_debounce_cnt: two parameterisations against a window-based model.
module tb_a3_debounce_cnt;

   logic ck, nrst, i0, i1, i2, snap_req;
   logic q0, qr0, sat0, vld0;
   logic [7:0] cnt0, sc0;
   logic q1, qr1, sat1, vld1;
   logic [1:0] cnt1, sc1;

   a3_debounce_cnt #(.DB_CYCLES(4), .CNT_W(8)) dut0 (
      .ck(ck), .nrst(nrst), .i0(i0), .i1(i1), .i2(i2),
      .q(q0), .qrise(qr0), .cnt(cnt0), .cnt_sat(sat0),
      .snap_req(snap_req), .snap_vld(vld0), .snap_cnt(sc0));

   a3_debounce_cnt #(.DB_CYCLES(2), .CNT_W(2)) dut1 (
      .ck(ck), .nrst(nrst), .i0(i0), .i1(i1), .i2(i2),
      .q(q1), .qrise(qr1), .cnt(cnt1), .cnt_sat(sat1),
      .snap_req(snap_req), .snap_vld(vld1), .snap_cnt(sc1));

   initial ck = 1'b0;
   always #5 ck = ~ck;

`ifdef A3_DEBOUNCE_SYNC_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif

   int n_chk = 0;
   int n_err = 0;
   int edge_n = 0;

   // model: s history since reset; q flips when the last DB samples all differ from q
   bit pipe[$];
   bit hist[$];
   int db[2] = '{4, 2};
   int mx[2] = '{255, 3};
   bit mq[2], mr[2], mv[2];
   int mc[2], ms[2];

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, act, exp);
      end
   endtask

   task automatic model_reset();
      pipe.delete();
      for (int j = 0; j < L; j++) pipe.push_back(1'b0);
      hist.delete();
      for (int k = 0; k < 2; k++) begin
         mq[k] = 0; mr[k] = 0; mv[k] = 0; mc[k] = 0; ms[k] = 0;
      end
   endtask

   task automatic model_edge();
      bit s, all;
      int nx;
      pipe.push_back(i0 & i1 & i2);
      s = pipe.pop_front();
      hist.push_back(s);
      if (hist.size() > 8) void'(hist.pop_front());
      for (int k = 0; k < 2; k++) begin
         all = 1;
         mr[k] = 0;
         if (hist.size() < db[k]) all = 0;
         else for (int j = 0; j < db[k]; j++)
            if (hist[hist.size() - 1 - j] == mq[k]) all = 0;
         if (all) begin
            mq[k] = !mq[k];
            mr[k] = mq[k];
         end
         nx = (mr[k] && mc[k] < mx[k]) ? mc[k] + 1 : mc[k];
         if (!mv[k] && snap_req) begin
            ms[k] = nx; mc[k] = 0; mv[k] = 1;
         end else begin
            mc[k] = nx;
            if (mv[k] && !snap_req) mv[k] = 0;
         end
      end
   endtask

   task automatic check_all();
      chk("q0", q0, mq[0]);       chk("qrise0", qr0, mr[0]);
      chk("cnt0", cnt0, mc[0]);   chk("sat0", sat0, int'(mc[0] == mx[0]));
      chk("vld0", vld0, mv[0]);   chk("snap0", sc0, ms[0]);
      chk("q1", q1, mq[1]);       chk("qrise1", qr1, mr[1]);
      chk("cnt1", cnt1, mc[1]);   chk("sat1", sat1, int'(mc[1] == mx[1]));
      chk("vld1", vld1, mv[1]);   chk("snap1", sc1, ms[1]);
   endtask

   task automatic tick();
      @(posedge ck);
      model_edge();
      edge_n++;
      #1;
      check_all();
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      #2;
      model_reset();
      chk("rst_q0", q0, 0);     chk("rst_qrise0", qr0, 0);  chk("rst_cnt0", cnt0, 0);
      chk("rst_sat0", sat0, 0); chk("rst_vld0", vld0, 0);   chk("rst_snap0", sc0, 0);
      chk("rst_q1", q1, 0);     chk("rst_cnt1", cnt1, 0);   chk("rst_vld1", vld1, 0);
      @(posedge ck);
      #1;
      nrst = 1'b1;
      edge_n = 0;
   endtask

   task automatic set_in(input bit a, input bit b, input bit c);
      i0 = a; i1 = b; i2 = c;
   endtask

   bit fell;
   int rise_edge;
   int hold;

   initial begin
      nrst = 1'b1; snap_req = 1'b0;
      set_in(1, 1, 1);
      #12;

      // reset with everything asserted, then release and let it settle
      snap_req = 1'b1;
      do_reset();
      repeat (10) tick();
      chk("rst_release_q0", q0, 1);
      snap_req = 1'b0;
      repeat (2) tick();

      // first rise timing from a clean reset
      set_in(0, 0, 0);
      do_reset();
      repeat (9) tick();
      set_in(1, 1, 1);
      rise_edge = -1;
      repeat (11) begin
         tick();
         if (q0 && rise_edge < 0) rise_edge = edge_n;
      end
      chk("rise_edge", rise_edge, 10 + L + 3);
      chk("cnt_after_rise", cnt0, 1);

      // 3-cycle glitch is filtered, 4-cycle glitch is not
      fell = 0;
      set_in(1, 0, 1);
      repeat (3) tick();
      set_in(1, 1, 1);
      repeat (8) begin tick(); if (!q0) fell = 1; end
      chk("glitch3_hold", fell, 0);
      set_in(1, 0, 1);
      repeat (4) begin tick(); if (!q0) fell = 1; end
      set_in(1, 1, 1);
      repeat (10) begin tick(); if (!q0) fell = 1; end
      chk("glitch4_fall", fell, 1);
      chk("cnt_two", cnt0, 2);

      // capture on the same edge as the third rise
      set_in(0, 0, 0);
      repeat (10) tick();
      set_in(1, 1, 1);
      repeat (L + 3) tick();
      snap_req = 1'b1;
      tick();
      chk("cap_qrise", qr0, 1);
      chk("cap_snap", sc0, 3);
      chk("cap_cnt", cnt0, 0);
      chk("cap_vld", vld0, 1);
      repeat (10) tick();
      chk("held_snap", sc0, 3);
      snap_req = 1'b0;
      tick();
      chk("drop_vld", vld0, 0);

      // five rises saturate the 2-bit counter
      repeat (5) begin
         set_in(0, 0, 0); repeat (8) tick();
         set_in(1, 1, 1); repeat (8) tick();
      end
      chk("sat_cnt1", cnt1, 3);
      chk("sat_flag1", sat1, 1);

      // random holds, random handshake, occasional reset
      for (int seg = 0; seg < 300; seg++) begin
         if ($urandom_range(0, 9) < 6) set_in(1, 1, 1);
         else set_in($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         hold = $urandom_range(1, 7);
         repeat (hold) begin
            if ($urandom_range(0, 5) == 0) snap_req = ~snap_req;
            tick();
         end
         if (seg % 97 == 96) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
